// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared port identifiers, widths and helpers for the VRAM arbiter
package vram_arbiter_pkg;
    localparam int PORT_DISP  = 0;
    localparam int PORT_DRAW  = 1;
    localparam int PORT_CPU   = 2;
    localparam int VRAM_PORTS = 3;
    localparam int STAT_W     = 32;

    typedef logic [1:0] port_id_t;

    function automatic logic [VRAM_PORTS-1:0] port_onehot(input port_id_t id);
        return VRAM_PORTS'(1) << id;
    endfunction
endpackage

// File: rtl/vram_arb_rpipe.sv
// vram_arb_rpipe: {valid, port-id} delay line that raises rvalid when read data comes back
module vram_arb_rpipe
    import vram_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys,
    input  logic                  in_valid,
    input  port_id_t              in_id,
    output logic [VRAM_PORTS-1:0] rvalid
);
    logic [DEPTH-1:0] v;
    port_id_t         id [DEPTH];

    // shift read tags one stage per cycle; reset drops anything in flight
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) id[i] <= '0;
        end else begin
            v     <= {v[DEPTH-2:0], in_valid};
            id[0] <= in_id;
            for (int i = 1; i < DEPTH; i++) id[i] <= id[i-1];
        end
    end

    assign rvalid = v[DEPTH-1] ? port_onehot(id[DEPTH-1]) : '0;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: three-port VRAM arbiter (display priority with starvation guard, draw/CPU round-robin); VRAM_ARBITER_STATS_EN adds per-port grant/wait counters
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDRW      = 16,
    parameter int DATAW      = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic                        clk_sys,
    input  logic                        rst_sys,
    input  logic [VRAM_PORTS-1:0]       req,
    input  logic [VRAM_PORTS-1:0]       we,
    input  logic [VRAM_PORTS*ADDRW-1:0] addr,
    input  logic [VRAM_PORTS*DATAW-1:0] wdata,
    output logic [VRAM_PORTS-1:0]       ready,
    output logic [VRAM_PORTS-1:0]       rvalid,
    output logic [DATAW-1:0]            rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDRW-1:0]            mem_addr,
    output logic [DATAW-1:0]            mem_wdata,
    input  logic [DATAW-1:0]            mem_rdata,
    input  logic [1:0]                  stat_sel,
    output logic [STAT_W-1:0]           stat_grant,
    output logic [STAT_W-1:0]           stat_wait
);
    localparam logic [7:0] SMAX = 8'(STARVE_MAX);

    logic [VRAM_PORTS-1:0] gnt;
    logic [7:0]            starve;
    logic                  rr_cpu;
    logic                  others;
    logic                  hold_disp;
    logic                  xfer;
    port_id_t              sel;

    // grant: display first unless it has starved a waiting port, then round-robin draw/CPU
    always_comb begin
        others         = req[PORT_DRAW] | req[PORT_CPU];
        hold_disp      = others && starve == SMAX;
        gnt            = '0;
        gnt[PORT_DISP] = req[PORT_DISP] && !hold_disp;
        gnt[PORT_DRAW] = !gnt[PORT_DISP] && req[PORT_DRAW] && !(rr_cpu && req[PORT_CPU]);
        gnt[PORT_CPU]  = !gnt[PORT_DISP] && req[PORT_CPU] && (rr_cpu || !req[PORT_DRAW]);
    end

    assign ready = rst_sys ? '0 : gnt;
    assign xfer  = |gnt;
    assign sel   = gnt[PORT_CPU] ? port_id_t'(PORT_CPU) : gnt[PORT_DRAW] ? port_id_t'(PORT_DRAW) : port_id_t'(PORT_DISP);

    // starvation counter and round-robin pointer
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            starve <= '0;
            rr_cpu <= 1'b0;
        end else begin
            if (gnt[PORT_DRAW] || gnt[PORT_CPU] || !others) starve <= '0;
            else if (gnt[PORT_DISP] && starve != SMAX) starve <= starve + 8'd1;
            if (gnt[PORT_DRAW]) rr_cpu <= 1'b1;
            else if (gnt[PORT_CPU]) rr_cpu <= 1'b0;
        end
    end

    // registered memory command; address and data hold when idle
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= xfer;
            mem_we <= xfer && we[sel];
            if (xfer) begin
                mem_addr  <= addr[sel*ADDRW +: ADDRW];
                mem_wdata <= wdata[sel*DATAW +: DATAW];
            end
        end
    end

    vram_arb_rpipe #(.DEPTH(MEM_LAT + 1)) u_rpipe (
        .clk_sys  (clk_sys),
        .rst_sys  (rst_sys),
        .in_valid (xfer && !we[sel]),
        .in_id    (sel),
        .rvalid   (rvalid)
    );

    assign rdata = |rvalid ? mem_rdata : '0;

`ifdef VRAM_ARBITER_STATS_EN
    logic [STAT_W-1:0] grant_cnt [VRAM_PORTS];
    logic [STAT_W-1:0] wait_cnt  [VRAM_PORTS];

    // wrapping per-port grant/wait counters with a registered readout
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            for (int i = 0; i < VRAM_PORTS; i++) begin
                grant_cnt[i] <= '0;
                wait_cnt[i]  <= '0;
            end
            stat_grant <= '0;
            stat_wait  <= '0;
        end else begin
            for (int i = 0; i < VRAM_PORTS; i++) begin
                if (gnt[i]) grant_cnt[i] <= grant_cnt[i] + STAT_W'(1);
                if (req[i] && !gnt[i]) wait_cnt[i] <= wait_cnt[i] + STAT_W'(1);
            end
            stat_grant <= stat_sel == 2'd3 ? '0 : grant_cnt[stat_sel];
            stat_wait  <= stat_sel == 2'd3 ? '0 : wait_cnt[stat_sel];
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_grant      = '0;
    assign stat_wait       = '0;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed stimulus with a cycle-level reference model of the VRAM arbiter
module tb_vram_arbiter;
    localparam int ADDRW      = 16;
    localparam int DATAW      = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 8;

    logic                 clk_sys = 0;
    logic                 rst_sys;
    logic [2:0]           req, we;
    logic [3*ADDRW-1:0]   addr;
    logic [3*DATAW-1:0]   wdata;
    logic [2:0]           ready, rvalid;
    logic [DATAW-1:0]     rdata, mem_wdata, mem_rdata;
    logic                 mem_en, mem_we;
    logic [ADDRW-1:0]     mem_addr;
    logic [1:0]           stat_sel;
    logic [31:0]          stat_grant, stat_wait;

    int checks = 0;
    int failures = 0;

    vram_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stat_sel(stat_sel), .stat_grant(stat_grant), .stat_wait(stat_wait)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [31:0] init_val(input int i);
        return i == 5 ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(i));
    endfunction

    // write-first BRAM with MEM_LAT=2 cycles from mem_en to mem_rdata
    logic [31:0] bram [256];
    logic [31:0] s1, s2;
    initial for (int i = 0; i < 256; i++) bram[i] <= init_val(i);
    always @(posedge clk_sys) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr[7:0]] <= mem_wdata;
            s1 <= mem_we ? mem_wdata : bram[mem_addr[7:0]];
        end
        s2 <= s1;
    end
    assign mem_rdata = s2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; int port; logic [31:0] data; } ret_t;
    ret_t        rq[$];
    logic [31:0] ref_mem [256];
    int          rr, starve, cyc;
    int          gcnt[3], wcnt[3];
    logic        m_en, m_we;
    logic [15:0] m_addr;
    logic [31:0] m_wdata, m_sg, m_sw;

    function automatic logic [2:0] pick(input logic [2:0] r);
        if (r[0] && !(starve == STARVE_MAX && (r[1] | r[2]))) return 3'b001;
        if (!(r[1] | r[2])) return 3'b000;
        if (r[rr]) return 3'(1 << rr);
        return 3'(1 << (3 - rr));
    endfunction

    task automatic model_reset();
        rr = 1; starve = 0;
        m_en = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_sg = 0; m_sw = 0;
        for (int i = 0; i < 3; i++) begin gcnt[i] = 0; wcnt[i] = 0; end
        rq.delete();
    endtask

    initial begin
        logic [2:0]  g;
        logic [2:0]  exp_rv;
        logic [31:0] exp_rd;
        int          p;
        ret_t        e;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        model_reset();
        cyc = 0;
        forever begin
            @(negedge clk_sys);
            if (rst_sys) model_reset();
            exp_rv = 0; exp_rd = 0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e = rq.pop_front();
                exp_rv = 3'(1 << e.port);
                exp_rd = e.data;
            end
            g = pick(rst_sys ? 3'b000 : req);
            chk("ready", ready, g);
            chk("mem_en", mem_en, m_en);
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("rvalid", rvalid, exp_rv);
            if (exp_rv != 0) chk("rdata", rdata, exp_rd);
            chk("stat_grant", stat_grant, m_sg);
            chk("stat_wait", stat_wait, m_sw);
            if (!rst_sys) begin
`ifdef VRAM_ARBITER_STATS_EN
                m_sg = stat_sel == 3 ? 0 : gcnt[stat_sel];
                m_sw = stat_sel == 3 ? 0 : wcnt[stat_sel];
`endif
                for (int n = 0; n < 3; n++) if (req[n] && !g[n]) wcnt[n]++;
                if (g != 0) begin
                    p = g[0] ? 0 : g[1] ? 1 : 2;
                    m_en = 1; m_we = we[p];
                    m_addr = addr[p*ADDRW +: ADDRW];
                    m_wdata = wdata[p*DATAW +: DATAW];
                    if (we[p]) ref_mem[m_addr[7:0]] = m_wdata;
                    else rq.push_back('{cyc + 1 + MEM_LAT, p, ref_mem[m_addr[7:0]]});
                    gcnt[p]++;
                end else begin
                    m_en = 0; m_we = 0;
                end
                if (g[1] || g[2] || !(req[1] || req[2])) starve = 0;
                else if (g[0] && starve < STARVE_MAX) starve++;
                if (g[1]) rr = 2;
                else if (g[2]) rr = 1;
            end
            cyc++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic setp(input int p, input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
        req[p] = r;
        we[p] = w;
        addr[p*ADDRW +: ADDRW] = a;
        wdata[p*DATAW +: DATAW] = d;
    endtask

    initial begin
        rst_sys = 1; req = 0; we = 0; addr = 0; wdata = 0; stat_sel = 0;
        repeat (3) tick();
        rst_sys = 0;
        tick();

        // draw and CPU read continuously: alternate starting with draw
        setp(1, 1, 0, 16'h0001, 0);
        setp(2, 1, 0, 16'h0002, 0);
        #1 chk("rr_c0_ready", ready, 3'b010);
        tick(); chk("rr_c1_ready", ready, 3'b100); chk("rr_c1_en", mem_en, 1); chk("rr_c1_addr", mem_addr, 16'h0001);
        tick(); chk("rr_c2_ready", ready, 3'b010); chk("rr_c2_en", mem_en, 1); chk("rr_c2_addr", mem_addr, 16'h0002);
        tick(); chk("rr_c3_ready", ready, 3'b100); chk("rr_c3_addr", mem_addr, 16'h0001);
        req = 0;
        repeat (6) tick();

        // single draw write
        setp(1, 1, 1, 16'h0010, 32'hDEAD_BEEF);
        #1 chk("wr_ready", ready, 3'b010);
        tick();
        req = 0;
        chk("wr_en", mem_en, 1); chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 16'h0010); chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        repeat (3) tick();

        // display writes continuously, draw reads the same word: starvation guard
        setp(0, 1, 1, 16'h0020, 32'hA5A5_0000);
        setp(1, 1, 0, 16'h0020, 0);
        #1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("starve_c%0d", k), ready, k == 8 ? 3'b010 : 3'b001);
            tick();
        end
        req = 0;
        tick();
        chk("starve_rvalid", rvalid, 3'b010); chk("starve_rdata", rdata, 32'hA5A5_0000);
        repeat (4) tick();

        // CPU read with MEM_LAT=2
        setp(2, 1, 0, 16'h0005, 0);
        #1 chk("lat_ready", ready, 3'b100);
        tick();
        req = 0;
        chk("lat_rv1", rvalid, 3'b000);
        tick(); chk("lat_rv2", rvalid, 3'b000);
        tick(); chk("lat_rv3", rvalid, 3'b100); chk("lat_rdata", rdata, 32'h1234_5678);
        tick(); chk("lat_rv4", rvalid, 3'b000);
        repeat (3) tick();

        // reset during an in-flight display read
        setp(0, 1, 0, 16'h0007, 0);
        #1 chk("rst_ready_pre", ready, 3'b001);
        tick();
        chk("rst_en_pre", mem_en, 1);
        rst_sys = 1;
        #1 chk("rst_en_async", mem_en, 0); chk("rst_ready_async", ready, 3'b000);
        tick(); tick();
        rst_sys = 0; req = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rst_norv%0d", k), rvalid, 3'b000);
        end

        // statistics: 3 draw waits then 10 draw grants
        stat_sel = 1;
        setp(0, 1, 1, 16'h0030, 32'h0);
        setp(1, 1, 1, 16'h0031, 32'h1);
        repeat (3) tick();
        req[0] = 0;
        repeat (10) tick();
        req = 0;
        tick();
`ifdef VRAM_ARBITER_STATS_EN
        chk("stat1_grant", stat_grant, 10); chk("stat1_wait", stat_wait, 3);
`else
        chk("stat1_grant", stat_grant, 0); chk("stat1_wait", stat_wait, 0);
`endif
        stat_sel = 0;
        tick(); tick();
`ifdef VRAM_ARBITER_STATS_EN
        chk("stat0_grant", stat_grant, 3); chk("stat0_wait", stat_wait, 0);
`else
        chk("stat0_grant", stat_grant, 0); chk("stat0_wait", stat_wait, 0);
`endif
        stat_sel = 3;
        tick(); tick();
        chk("stat3_grant", stat_grant, 0); chk("stat3_wait", stat_wait, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
